// File: rtl/seg_scan_mux.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seg_scan_mux : 3-digit segment scanner with per-frame snapshot/blanking |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module seg_scan_mux #(
   parameter int         SCAN_DIV  = 1000,
   parameter int         BLANK_CYC = 4,
   parameter logic [7:0] SEG_OFF   = 8'hFF,
   parameter int         CNT_W     = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       En,
   input  logic       Hold,
   input  logic [7:0] S0,
   input  logic [7:0] S1,
   input  logic [7:0] S2,
   output logic [7:0] Seg,
   output logic [2:0] Dig,
   output logic       Frame
);

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam bit               HAS_BLANK  = (BLANK_CYC > 0);
   localparam logic [2:0]       DIG_OFF    = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t           state;
   logic [1:0]       idx;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       sh0;
   logic [7:0]       sh1;
   logic [7:0]       sh2;

   logic             show_done;
   logic             blank_done;
   logic             frame_start;
   logic [1:0]       idx_next;
   logic [7:0]       snap0;
   logic [7:0]       snap1;
   logic [7:0]       snap2;

   function automatic logic [2:0] dig_sel(input logic [1:0] i);
      case (i)
         2'd0:    dig_sel = 3'b110;
         2'd1:    dig_sel = 3'b101;
         2'd2:    dig_sel = 3'b011;
         default: dig_sel = 3'b111;
      endcase
   endfunction

   function automatic logic [7:0] seg_sel(input logic [1:0] i, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] c);
      case (i)
         2'd0:    seg_sel = a;
         2'd1:    seg_sel = b;
         2'd2:    seg_sel = c;
         default: seg_sel = SEG_OFF;
      endcase
   endfunction

   always_comb begin
      show_done   = (state == SHOW)  && (cnt == SHOW_LAST);
      blank_done  = (state == BLANK) && (cnt == BLANK_LAST);
      frame_start = En && ((state == IDLE) || (show_done && (idx == 2'd2)));
      idx_next    = idx + 2'd1;
      // Values the shadows will hold after a frame-start edge.
      snap0       = Hold ? sh0 : S0;
      snap1       = Hold ? sh1 : S1;
      snap2       = Hold ? sh2 : S2;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         idx   <= 2'd0;
         cnt   <= '0;
         Dig   <= DIG_OFF;
         Seg   <= SEG_OFF;
         Frame <= 1'b0;
         sh0   <= SEG_OFF;
         sh1   <= SEG_OFF;
         sh2   <= SEG_OFF;
      end else if (!En) begin
         state <= IDLE;
         idx   <= 2'd0;
         cnt   <= '0;
         Dig   <= DIG_OFF;
         Seg   <= SEG_OFF;
         Frame <= 1'b0;
      end else if (frame_start) begin
         idx   <= 2'd0;
         cnt   <= '0;
         Frame <= 1'b1;
         sh0   <= snap0;
         sh1   <= snap1;
         sh2   <= snap2;
         if (HAS_BLANK) begin
            state <= BLANK;
            Dig   <= DIG_OFF;
            Seg   <= SEG_OFF;
         end else begin
            state <= SHOW;
            Dig   <= dig_sel(2'd0);
            Seg   <= snap0;
         end
      end else begin
         Frame <= 1'b0;
         case (state)
            BLANK: begin
               if (blank_done) begin
                  state <= SHOW;
                  cnt   <= '0;
                  Dig   <= dig_sel(idx);
                  Seg   <= seg_sel(idx, sh0, sh1, sh2);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SHOW: begin
               // The idx==2 wrap is taken by the frame_start branch above.
               if (show_done) begin
                  idx <= idx_next;
                  cnt <= '0;
                  if (HAS_BLANK) begin
                     state <= BLANK;
                     Dig   <= DIG_OFF;
                     Seg   <= SEG_OFF;
                  end else begin
                     state <= SHOW;
                     Dig   <= dig_sel(idx_next);
                     Seg   <= seg_sel(idx_next, sh0, sh1, sh2);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               idx   <= 2'd0;
               cnt   <= '0;
               Dig   <= DIG_OFF;
               Seg   <= SEG_OFF;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Downstream display stage for the stopwatch. It takes the three 8-bit segment patterns S0, S1 and S2 and time-multiplexes them onto one shared segment bus with per-digit enables, to drive a common-anode 3-digit display. All three digits are snapshotted together at each frame start, so a count never tears within a frame. A blanking gap between digits suppresses ghosting.

Parameters:
SCAN_DIV, 1000, clock cycles each digit is lit (SHOW length); legal range >= 1.
BLANK_CYC, 4, clock cycles of all-off before each digit (BLANK length); 0 removes the BLANK state.
SEG_OFF, 8'hFF, pattern driven on Seg when no digit is lit.
CNT_W, 16, width of the internal phase counter; must hold max(SCAN_DIV, BLANK_CYC).

Ports:
Clk  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-high reset.
En  input  1  scan enable, level-sensitive.
Hold  input  1  when 1 at a frame start, the snapshot is skipped and the previous values are kept.
S0  input  8  segment pattern for digit 0, passed through unmodified.
S1  input  8  segment pattern for digit 1.
S2  input  8  segment pattern for digit 2.
Seg  output  8  shared segment bus, registered.
Dig  output  3  digit enables, active-low, one-hot-low; bit i selects digit i; registered.
Frame  output  1  one-cycle pulse on the first cycle of each frame, registered.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, idx=0, cnt=0, Dig=3'b111, Seg=SEG_OFF, Frame=0.
  - Shadow registers sh0/sh1/sh2 = SEG_OFF.
- State machine: IDLE, BLANK, SHOW.
  - All outputs are registered and reflect the state entered on the same edge.
- IDLE:
  - Outputs: Dig=111, Seg=SEG_OFF.
  - On an edge with En=1, start a frame.
- Frame start:
  - Occurs on leaving IDLE, and on the SHOW→next transition when idx==2.
  - idx<=0, cnt<=0, Frame<=1 for exactly one cycle.
  - If Hold=0, sh0..sh2 <= S0..S2, all captured on that edge.
  - If Hold=1, the shadows are unchanged.
  - Next state is BLANK, or SHOW directly if BLANK_CYC==0.
- BLANK:
  - Outputs: Dig=111, Seg=SEG_OFF.
  - Lasts exactly BLANK_CYC cycles, then moves to SHOW with cnt cleared.
- SHOW:
  - Outputs: Dig bit idx=0 and the others 1; Seg = sh[idx].
  - Lasts exactly SCAN_DIV cycles.
  - Then if idx<2: idx<=idx+1 and go to BLANK (or SHOW directly if BLANK_CYC==0).
  - If idx==2: frame start (wraps to 0).
- Frame period = 3*(BLANK_CYC+SCAN_DIV) cycles, exactly and repeatedly.
- Frame is 0 in every cycle other than the first cycle of a frame.
- En=0 sampled on any edge outside IDLE:
  - Next state is IDLE and outputs go off on that edge.
  - idx and cnt clear; shadows are retained.
  - Re-enabling always restarts at a frame start (digit 0), never mid-frame.
- Input changes:
  - S0..S2 changes mid-frame have no effect until the next frame start.
  - Hold is sampled only at frame starts.
- Dig is never 000 or two-low. At most one digit is lit in any cycle, including across transitions.
- Simultaneous events:
  - Reset dominates everything.
  - En=0 dominates a coincident frame start: no snapshot and no Frame pulse.

Test Plan:
- Parameters for the bench: SCAN_DIV=4, BLANK_CYC=2.
- Reset asserted mid-SHOW, asynchronously between edges → Dig=111, Seg=FF, Frame=0 immediately, before the next edge.
- En rises with S0=C0, S1=F9, S2=A4 → Frame=1 for 1 cycle, then:
  - 2 cycles Dig=111; 4 cycles Dig=110, Seg=C0;
  - 2 cycles off; 4 cycles Dig=101, Seg=F9;
  - 2 cycles off; 4 cycles Dig=011, Seg=A4;
  - next Frame pulse 18 cycles after the first.
- S0 changes from C0 to 92 during digit-1 SHOW → Seg stays C0 for digit 0 for the rest of that frame; shows 92 from the next frame.
- Hold=1 at a frame start with S1 changed to 99 → Frame still pulses; digit 1 keeps showing F9 that frame. With Hold=0 at the following start, it shows 99.
- En=0 during digit-2 SHOW → next edge Dig=111, Seg=FF, state IDLE. En=1 again → Frame pulse and the sequence restarts at digit 0 with fresh values.
- Rebuild with BLANK_CYC=0 → no all-off cycles between digits; Dig sequence 110×4, 101×4, 011×4; Frame period 12 cycles.
